menu_song_ctrl: RTL

MENU_SONG_CTRL -- requirements
Module: menu_song_ctrl

---
 rtl/menu_song_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/menu_song_ctrl.sv
// Song-select menu controller: debounced buttons drive a MENU -> ARM -> PLAY flow.
// Each button gets its own sync/debounce/edge-detect lane; all FSM outputs are registered.

module menu_btn_db #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        // Any cycle where the synchronized input agrees with the level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

module menu_song_ctrl #(
    parameter int NUM_SONGS   = 4,
    parameter int DB_CYCLES   = 1000000,
    parameter int START_DELAY = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    input  logic       btn_back,
    input  logic       game_over,
    output logic       menu_enabled,
    output logic [1:0] song,
    output logic       start_game,
    output logic       playing,
    output logic       countdown_active
);
    localparam int NUM_BTN = 4;
    localparam int DW = $clog2(START_DELAY + 1);
    localparam logic [DW-1:0] DLY_LOAD  = DW'(START_DELAY - 1);
    localparam logic [1:0]    LAST_SONG = 2'(NUM_SONGS - 1);

    typedef enum logic [1:0] {MENU, ARM, PLAY} state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_back, btn_ok, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        menu_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .press  (press[i])
        );
    end

    logic up_ev, down_ev, ok_ev, back_ev;
    assign up_ev   = press[0];
    assign down_ev = press[1];
    assign ok_ev   = press[2];
    assign back_ev = press[3];

    state_t        state_q, state_d;
    logic [1:0]    song_q, song_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          menu_en_q, menu_en_d;
    logic          start_q, start_d;
    logic          playing_q, playing_d;
    logic          cd_q, cd_d;

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        dly_d   = dly_q;
        start_d = 1'b0;
        unique case (state_q)
            MENU: begin
                if (ok_ev) begin
                    state_d = ARM;
                    dly_d   = DLY_LOAD;
                end else if (up_ev && !down_ev) begin
                    song_d = (song_q == LAST_SONG) ? 2'd0 : song_q + 2'd1;
                end else if (down_ev && !up_ev) begin
                    song_d = (song_q == 2'd0) ? LAST_SONG : song_q - 2'd1;
                end
            end
            ARM: begin
                // Back beats a same-cycle terminal count: the game must not start.
                if (back_ev) begin
                    state_d = MENU;
                    dly_d   = '0;
                end else if (dly_q == '0) begin
                    state_d = PLAY;
                    start_d = 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            PLAY: begin
                if (game_over || back_ev) begin
                    state_d = MENU;
                end
            end
            default: state_d = MENU;
        endcase
        menu_en_d = (state_d != PLAY);
        playing_d = (state_d == PLAY);
        cd_d      = (state_d == ARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MENU;
            song_q    <= 2'd0;
            dly_q     <= '0;
            menu_en_q <= 1'b1;
            start_q   <= 1'b0;
            playing_q <= 1'b0;
            cd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            dly_q     <= dly_d;
            menu_en_q <= menu_en_d;
            start_q   <= start_d;
            playing_q <= playing_d;
            cd_q      <= cd_d;
        end
    end

    assign menu_enabled     = menu_en_q;
    assign song             = song_q;
    assign start_game       = start_q;
    assign playing          = playing_q;
    assign countdown_active = cd_q;
endmodule
